// File: rtl/array_mult_sched.sv
// Issue scheduler and result buffer for an N-lane 27x27 array multiplier.
// Operands are registered into a free-running multiplier; a shadow valid/tag pipe lands results in a show-ahead FIFO.
module array_mult_sched #(
  parameter int N          = 15,
  parameter int W          = 27,
  parameter int MULT_LAT   = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int TAG_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0][W-1:0]   in_a,
  input  logic [N-1:0][W-1:0]   in_b,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  m_en,
  output logic [N-1:0][W-1:0]   m_dataa,
  output logic [N-1:0][W-1:0]   m_datab,
  input  logic [N-1:0][W-1:0]   m_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0][W-1:0]   out_data,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SH    = MULT_LAT + 1;

  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_busy;
  logic [N-1:0][W-1:0]  r_dataa;
  logic [N-1:0][W-1:0]  r_datab;
  logic                 r_issue_v;
  logic [TAG_W-1:0]     r_issue_tag;
  logic [SH-1:0]        r_sh_v;
  logic [TAG_W-1:0]     r_sh_tag [SH];
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_next;
  logic [N-1:0][W-1:0]  r_mem_data [FIFO_DEPTH];
  logic [TAG_W-1:0]     r_mem_tag [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_fcnt;
  logic [CNT_W-1:0]     w_fcnt_next;
  logic                 w_accept;
  logic                 w_pop;
  logic                 w_wr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign w_accept = in_valid & r_in_ready;
  assign w_pop    = r_out_valid & out_ready;
  // The last shadow stage lines up with the multiplier's ungated round register.
  assign w_wr     = r_sh_v[SH-1];

  // Outstanding-op credit: accepted and not yet popped.
  always_comb begin
    w_cnt_next = r_cnt;
    case ({w_accept, w_pop})
      2'b10:   w_cnt_next = r_cnt + CNT_W'(1);
      2'b01:   w_cnt_next = r_cnt - CNT_W'(1);
      default: w_cnt_next = r_cnt;
    endcase
  end

  // FIFO occupancy next value.
  always_comb begin
    w_fcnt_next = r_fcnt;
    case ({w_wr, w_pop})
      2'b10:   w_fcnt_next = r_fcnt + CNT_W'(1);
      2'b01:   w_fcnt_next = r_fcnt - CNT_W'(1);
      default: w_fcnt_next = r_fcnt;
    endcase
  end

  // Operand capture and shadow valid/tag pipe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_issue_v   <= 1'b0;
      r_issue_tag <= '0;
      r_dataa     <= '0;
      r_datab     <= '0;
      r_sh_v      <= '0;
      for (int k = 0; k < SH; k++) begin
        r_sh_tag[k] <= '0;
      end
    end else begin
      r_issue_v <= w_accept;
      if (w_accept) begin
        r_dataa     <= in_a;
        r_datab     <= in_b;
        r_issue_tag <= in_tag;
      end
      r_sh_v      <= {r_sh_v[SH-2:0], r_issue_v};
      r_sh_tag[0] <= r_issue_tag;
      for (int k = 1; k < SH; k++) begin
        r_sh_tag[k] <= r_sh_tag[k-1];
      end
    end
  end

  // Result FIFO storage and pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fcnt   <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        r_mem_data[k] <= '0;
        r_mem_tag[k]  <= '0;
      end
    end else begin
      if (w_wr) begin
        r_mem_data[r_wr_ptr] <= m_result;
        r_mem_tag[r_wr_ptr]  <= r_sh_tag[SH-1];
        r_wr_ptr             <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_fcnt <= w_fcnt_next;
    end
  end

  // Registered status: in_ready looks only at the next credit, never at out_ready directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_next;
      r_in_ready  <= (w_cnt_next < CNT_W'(FIFO_DEPTH));
      r_out_valid <= (w_fcnt_next != '0);
      r_busy      <= (w_cnt_next != '0);
    end
  end

  assign in_ready  = r_in_ready;
  assign m_en      = r_issue_v | (|r_sh_v);
  assign m_dataa   = r_dataa;
  assign m_datab   = r_datab;
  assign out_valid = r_out_valid;
  assign out_data  = r_mem_data[r_rd_ptr];
  assign out_tag   = r_mem_tag[r_rd_ptr];
  assign busy      = r_busy;

endmodule

// File: tb/tb_array_mult_sched.sv
// Bench for array_mult_sched: behavioural multiplier model, scoreboard monitor,
// table of single-op vectors and directed sequences for back-pressure, credit and reset.
module tb_array_mult_sched;
  localparam int N = 15, W = 27, MULT_LAT = 3, FIFO_DEPTH = 8, TAG_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset_n, in_valid, in_ready, m_en, out_valid, out_ready, busy;
  logic [N-1:0][W-1:0] in_a, in_b, m_dataa, m_datab, m_result, out_data;
  logic [TAG_W-1:0]    in_tag, out_tag;

  array_mult_sched #(.N(N), .W(W), .MULT_LAT(MULT_LAT), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .m_en(m_en),
    .m_dataa(m_dataa), .m_datab(m_datab), .m_result(m_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .busy(busy)
  );

  int checks = 0, failures = 0, n_pops = 0;

  function automatic logic [W-1:0] rnd(input logic [2*W-1:0] p);
    return p[W+7:8] + {{(W-1){1'b0}}, p[7]};
  endfunction

  function automatic logic [N-1:0][2*W-1:0] prodvec(input logic [N-1:0][W-1:0] a, input logic [N-1:0][W-1:0] b);
    logic [N-1:0][2*W-1:0] r;
    for (int i = 0; i < N; i++) r[i] = {{W{1'b0}}, a[i]} * {{W{1'b0}}, b[i]};
    return r;
  endfunction

  function automatic logic [N-1:0][W-1:0] roundvec(input logic [N-1:0][2*W-1:0] p);
    logic [N-1:0][W-1:0] r;
    for (int i = 0; i < N; i++) r[i] = rnd(p[i]);
    return r;
  endfunction

  // External multiplier: MULT_LAT enable-gated stages followed by an ungated round register.
  logic [N-1:0][2*W-1:0] st [MULT_LAT];
  logic [N-1:0][W-1:0]   round_r;
  always_ff @(posedge clk) begin
    if (m_en) begin
      st[0] <= prodvec(m_dataa, m_datab);
      for (int k = 1; k < MULT_LAT; k++) st[k] <= st[k-1];
    end
    round_r <= roundvec(st[MULT_LAT-1]);
  end
  assign m_result = round_r;

  task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N-1:0][W-1:0] data;
    logic [TAG_W-1:0]    tag;
  } exp_t;
  exp_t sb[$];

  // Scoreboard: push on accept, compare on pop; a reset discards everything in flight.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected: got tag %0h with empty scoreboard", out_tag);
          end else begin
            e = sb.pop_front();
            chk("sb_data", out_data, e.data);
            chk("sb_tag", N*W'(out_tag), N*W'(e.tag));
            n_pops++;
          end
        end
        if (in_valid && in_ready) begin
          e.data = roundvec(prodvec(in_a, in_b));
          e.tag  = in_tag;
          sb.push_back(e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int               lane;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W-1:0]     exp;
    logic [TAG_W-1:0] tag;
  } vec_t;
  vec_t tbl [7];

  initial begin : stim
    int en_cnt, lat, acc, pops0, hi_cnt, first_k, last_k;
    logic [N-1:0][W-1:0] ev;

    tbl[0] = '{0,  27'h100,     27'h100,     27'h100,     4'd5};
    tbl[1] = '{3,  27'h1,       27'h80,      27'h1,       4'd1};
    tbl[2] = '{4,  27'h1,       27'h7F,      27'h0,       4'd2};
    tbl[3] = '{14, 27'h7FFFFFF, 27'h7FFFFFF, 27'h7F00000, 4'd3};
    tbl[4] = '{7,  27'h180,     27'h100,     27'h180,     4'd4};
    tbl[5] = '{1,  27'h3,       27'h55,      27'h1,       4'd6};
    tbl[6] = '{6,  27'd2097024, 27'd16385,   27'h0,       4'd7};

    reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    tick(); tick(); tick();
    chk("rst_out_valid", N*W'(out_valid), '0);
    chk("rst_in_ready", N*W'(in_ready), '0);
    chk("rst_m_en", N*W'(m_en), '0);
    chk("rst_busy", N*W'(busy), '0);
    reset_n = 1'b1;
    tick();
    chk("rst_release_ready", N*W'(in_ready), N*W'(1'b1));

    // Single ops from the table: latency, enable window, lane result and tag.
    for (int t = 0; t < 7; t++) begin
      in_a = '0; in_b = '0;
      in_a[tbl[t].lane] = tbl[t].a;
      in_b[tbl[t].lane] = tbl[t].b;
      in_tag = tbl[t].tag;
      in_valid = 1'b1;
      chk("tbl_ready", N*W'(in_ready), N*W'(1'b1));
      tick();
      in_valid = 1'b0;
      en_cnt = 0; lat = 0;
      ev = '0;
      ev[tbl[t].lane] = tbl[t].exp;
      for (int k = 0; k < 12; k++) begin
        if (m_en) en_cnt++;
        if (out_valid && lat == 0) begin
          lat = k;
          chk("tbl_data", out_data, ev);
          chk("tbl_tag", N*W'(out_tag), N*W'(tbl[t].tag));
        end
        tick();
      end
      chk("tbl_latency", N*W'(lat), N*W'(MULT_LAT + 2));
      chk("tbl_m_en_cycles", N*W'(en_cnt), N*W'(MULT_LAT + 2));
    end

    // 20 back-to-back ops with the consumer always ready.
    pops0 = n_pops; hi_cnt = 0; first_k = -1; last_k = -1;
    for (int i = 0; i < 35; i++) begin
      if (i < 20) begin
        for (int l = 0; l < N; l++) begin
          in_a[l] = W'($urandom());
          in_b[l] = W'($urandom());
        end
        in_tag = TAG_W'(i);
        in_valid = 1'b1;
        chk("b2b_ready", N*W'(in_ready), N*W'(1'b1));
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (out_valid) begin
        hi_cnt++;
        if (first_k < 0) first_k = i;
        last_k = i;
      end
    end
    chk("b2b_valid_cycles", N*W'(hi_cnt), N*W'(20));
    chk("b2b_contiguous", N*W'(last_k - first_k), N*W'(19));
    chk("b2b_pops", N*W'(n_pops - pops0), N*W'(20));

    // Consumer stalled: exactly FIFO_DEPTH accepts, then drain in order.
    out_ready = 1'b0; acc = 0; pops0 = n_pops;
    for (int i = 0; i < 14; i++) begin
      for (int l = 0; l < N; l++) in_a[l] = W'($urandom());
      in_b = in_a;
      in_tag = TAG_W'(i);
      in_valid = 1'b1;
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    chk("stall_accepts", N*W'(acc), N*W'(FIFO_DEPTH));
    chk("stall_in_ready_low", N*W'(in_ready), '0);
    for (int i = 0; i < 8; i++) tick();
    chk("stall_out_valid", N*W'(out_valid), N*W'(1'b1));
    out_ready = 1'b1;
    chk("stall_ready_before_pop", N*W'(in_ready), '0);
    tick();
    chk("stall_ready_after_pop", N*W'(in_ready), N*W'(1'b1));
    for (int i = 0; i < 20 && out_valid; i++) tick();
    tick();
    chk("stall_pops", N*W'(n_pops - pops0), N*W'(FIFO_DEPTH));

    // Credit at 7 with simultaneous accept+pop, then 8 with pop only.
    out_ready = 1'b0; pops0 = n_pops;
    for (int i = 0; i < 7; i++) begin
      in_a = '0; in_b = '0;
      in_a[2] = W'(i + 2); in_b[2] = W'(27'h100);
      in_tag = TAG_W'(i + 8);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("cnt7_out_valid", N*W'(out_valid), N*W'(1'b1));
    chk("cnt7_in_ready", N*W'(in_ready), N*W'(1'b1));
    in_tag = 4'hE; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("cnt7_hold_ready", N*W'(in_ready), N*W'(1'b1));
    chk("cnt7_busy", N*W'(busy), N*W'(1'b1));
    in_tag = 4'hF; out_ready = 1'b0;
    tick();
    chk("cnt8_full", N*W'(in_ready), '0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("cnt8_pop_ready", N*W'(in_ready), N*W'(1'b1));
    for (int i = 0; i < 30 && busy; i++) tick();
    chk("cnt_drain_busy", N*W'(busy), '0);
    chk("cnt_drain_valid", N*W'(out_valid), '0);
    chk("cnt_pops", N*W'(n_pops - pops0), N*W'(9));

    // Reset with 3 ops in the multiplier and 2 in the FIFO.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int l = 0; l < N; l++) in_a[l] = W'($urandom());
      in_b = in_a;
      in_tag = TAG_W'(i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    chk("pre_rst_out_valid", N*W'(out_valid), N*W'(1'b1));
    chk("pre_rst_m_en", N*W'(m_en), N*W'(1'b1));
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", N*W'(out_valid), '0);
    chk("mid_rst_in_ready", N*W'(in_ready), '0);
    chk("mid_rst_m_en", N*W'(m_en), '0);
    chk("mid_rst_busy", N*W'(busy), '0);
    tick(); tick();
    out_ready = 1'b1;
    reset_n = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) hi_cnt++;
    end
    chk("post_rst_no_result", N*W'(hi_cnt), '0);
    chk("post_rst_in_ready", N*W'(in_ready), N*W'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
